// File: rtl/bram16_dma_pkg.sv
// Shared encodings for the bram16 DMA initiator: FSM states and transfer modes.
package bram16_dma_pkg;

    // RD: read address on bus, CAP: read data valid, WR: write on bus
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_CAP  = 2'd2,
        ST_WR   = 2'd3
    } state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/bram16_dma.sv
// DMA initiator for a 16-bit block-RAM port with 1-cycle registered read.
// Copies len words src->dst (3 cycles/word) or fills len words with fill_val
// (1 cycle/word). Owns the single RAM port while busy. All outputs registered.
// The RAM write-data port is named dout because "do" is a reserved word.
module bram16_dma
    import bram16_dma_pkg::*;
#(
    parameter int adr_width = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic [15:0] fill_val,
    output logic        busy,
    output logic        done,
    output logic [15:0] sum,
    output logic [15:0] a,
    output logic [15:0] dout,
    output logic        we,
    input  logic [15:0] di
);

    // word-index width inside the RAM; indices wrap naturally at this width
    localparam int WW = adr_width - 1;

    state_t          state_q, state_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            we_q, we_d;
    logic [15:0]     sum_q, sum_d;
    logic [15:0]     a_q, a_d;
    logic [15:0]     dout_q, dout_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [WW-1:0]   src_q, src_d;
    logic [WW-1:0]   dst_q, dst_d;
    logic            mode_q, mode_d;
    logic [15:0]     fill_q, fill_d;
    logic [WW-1:0]   src_inc, dst_inc;

    // byte address bits above the RAM and bit 0 are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{src[15:adr_width], src[0], dst[15:adr_width], dst[0]};

    // word index -> bus byte address, upper bits and bit 0 forced to 0
    function automatic logic [15:0] byte_adr(input logic [WW-1:0] w);
        return 16'({w, 1'b0});
    endfunction

    assign src_inc = src_q + 1'b1;
    assign dst_inc = dst_q + 1'b1;

    // next-state and registered-output computation
    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        sum_d   = sum_q;
        a_d     = a_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        dst_d   = dst_q;
        mode_d  = mode_q;
        fill_d  = fill_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    src_d  = src[WW:1];
                    dst_d  = dst[WW:1];
                    cnt_d  = len;
                    mode_d = mode;
                    fill_d = fill_val;
                    sum_d  = 16'h0000;
                    busy_d = 1'b1;
                    if (len == 16'h0000) begin
                        // empty transfer: one idle-bus cycle in RD, then done
                        state_d = ST_RD;
                    end else if (mode == MODE_FILL) begin
                        state_d = ST_WR;
                        a_d     = byte_adr(dst[WW:1]);
                        dout_d  = fill_val;
                        we_d    = 1'b1;
                        sum_d   = fill_val;
                    end else begin
                        state_d = ST_RD;
                        a_d     = byte_adr(src[WW:1]);
                    end
                end
            end
            ST_RD: begin
                if (cnt_q == 16'h0000) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                // di is valid now; capture it straight into the write register
                state_d = ST_WR;
                a_d     = byte_adr(dst_q);
                dout_d  = di;
                we_d    = 1'b1;
                sum_d   = sum_q + di;
            end
            ST_WR: begin
                if (cnt_q == 16'h0001) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 16'h0001;
                    dst_d = dst_inc;
                    if (mode_q == MODE_FILL) begin
                        a_d    = byte_adr(dst_inc);
                        dout_d = fill_q;
                        we_d   = 1'b1;
                        sum_d  = sum_q + fill_q;
                    end else begin
                        state_d = ST_RD;
                        src_d   = src_inc;
                        a_d     = byte_adr(src_inc);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // abort only matters while busy; a write already on the bus still lands
        if (busy_q && abort) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
            we_d    = 1'b0;
            sum_d   = sum_q;
            a_d     = a_q;
            dout_d  = dout_q;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            sum_q   <= 16'h0000;
            a_q     <= 16'h0000;
            dout_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
            src_q   <= '0;
            dst_q   <= '0;
            mode_q  <= MODE_COPY;
            fill_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign a    = a_q;
    assign dout = dout_q;
    assign we   = we_q;

endmodule
